// File: rtl/eth_pkt_queue_tracker.sv
// TX frame queue tracker: frame count, head-of-line length FIFO, queued byte total,
// and sticky overflow/underflow flags for the MAC TX path.
module eth_pkt_queue_tracker #(
  parameter  int MAX_PKTS  = 4,
  parameter  int LEN_W     = 11,
  parameter  int AF_THRESH = 3,
  localparam int CNT_W     = $clog2(MAX_PKTS + 1),
  localparam int BYTES_W   = LEN_W + $clog2(MAX_PKTS + 1)
) (
  input  logic               eth_tx_clk,
  input  logic               rst,
  input  logic               bf_in_pct_qued,
  input  logic [LEN_W-1:0]   bf_in_pct_len,
  input  logic               bf_in_pct_txed,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   bf_out_buffer_ready,
  output logic               bf_out_empty,
  output logic               bf_out_full,
  output logic               bf_out_almost_full,
  output logic               bf_out_head_vld,
  output logic [LEN_W-1:0]   bf_out_head_len,
  output logic [BYTES_W-1:0] bf_out_total_bytes,
  output logic               bf_out_ovf,
  output logic               bf_out_udf
);

  localparam int PTR_W = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKTS);
  localparam logic [CNT_W-1:0] AF_CNT  = CNT_W'(AF_THRESH);

  logic [LEN_W-1:0]   mem [MAX_PKTS];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [BYTES_W-1:0] total_q, total_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;

  logic               push_acc, pop_acc;
  logic [LEN_W-1:0]   head_mem;
  logic [BYTES_W-1:0] add_bytes, sub_bytes;

  assign head_mem = mem[rd_ptr_q];

  // A push into a full queue is only legal when the head is leaving this same cycle.
  assign pop_acc  = bf_in_pct_txed && (cnt_q != '0);
  assign push_acc = bf_in_pct_qued && ((cnt_q != MAX_CNT) || pop_acc);

  assign add_bytes = push_acc ? {{(BYTES_W-LEN_W){1'b0}}, bf_in_pct_len} : '0;
  assign sub_bytes = pop_acc  ? {{(BYTES_W-LEN_W){1'b0}}, head_mem}      : '0;

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    total_d  = total_q + add_bytes - sub_bytes;
    case ({push_acc, pop_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
    // Set beats clear so an error in the clearing cycle is not lost.
    ovf_d = (ovf_q && !err_clr) || (bf_in_pct_qued && !push_acc);
    udf_d = (udf_q && !err_clr) || (bf_in_pct_txed && !pop_acc);
  end

  always_ff @(posedge eth_tx_clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      total_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      total_q  <= total_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge eth_tx_clk) begin
    if (push_acc && !rst) mem[wr_ptr_q] <= bf_in_pct_len;
  end

  assign bf_out_buffer_ready = cnt_q;
  assign bf_out_empty        = (cnt_q == '0);
  assign bf_out_full         = (cnt_q == MAX_CNT);
  assign bf_out_almost_full  = (cnt_q >= AF_CNT);
  assign bf_out_head_vld     = (cnt_q != '0);
  assign bf_out_head_len     = (cnt_q != '0) ? head_mem : '0;
  assign bf_out_total_bytes  = total_q;
  assign bf_out_ovf          = ovf_q;
  assign bf_out_udf          = udf_q;

endmodule

// File: tb/tb_eth_pkt_queue_tracker.sv
// Self-checking bench for eth_pkt_queue_tracker using a queue-based reference FIFO.
module tb_eth_pkt_queue_tracker;

  localparam int MAX = 4;
  localparam int LW  = 11;
  localparam int AF  = 3;
  localparam int CW  = $clog2(MAX + 1);
  localparam int BW  = LW + $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          qued = 1'b0;
  logic [LW-1:0] len = '0;
  logic          txed = 1'b0;
  logic          clr = 1'b0;
  logic [CW-1:0] cnt;
  logic          empty, full, afull, hvld, ovf, udf;
  logic [LW-1:0] hlen;
  logic [BW-1:0] total;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  eth_pkt_queue_tracker #(.MAX_PKTS(MAX), .LEN_W(LW), .AF_THRESH(AF)) dut (
    .eth_tx_clk          (clk),
    .rst                 (rst),
    .bf_in_pct_qued      (qued),
    .bf_in_pct_len       (len),
    .bf_in_pct_txed      (txed),
    .err_clr             (clr),
    .bf_out_buffer_ready (cnt),
    .bf_out_empty        (empty),
    .bf_out_full         (full),
    .bf_out_almost_full  (afull),
    .bf_out_head_vld     (hvld),
    .bf_out_head_len     (hlen),
    .bf_out_total_bytes  (total),
    .bf_out_ovf          (ovf),
    .bf_out_udf          (udf)
  );

  always #5 clk = ~clk;

  function automatic int m_head();
    return (exp_q.size() > 0) ? exp_q[0] : 0;
  endfunction

  function automatic int m_sum();
    int s = 0;
    foreach (exp_q[i]) s += exp_q[i];
    return s;
  endfunction

  // Drive one cycle of stimulus and advance the reference model; outputs sampled 1ns after the edge.
  task automatic step(input bit q, input int l, input bit t, input bit c);
    bit pop, push;
    qued = q; len = LW'(l); txed = t; clr = c;
    @(posedge clk);
    pop  = t && (exp_q.size() > 0);
    push = q && ((exp_q.size() < MAX) || pop);
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(l);
    m_ovf = (m_ovf && !c) || (q && !push);
    m_udf = (m_udf && !c) || (t && !pop);
    #1;
    qued = 1'b0; txed = 1'b0; clr = 1'b0; len = '0;
    $display("[TB] cyc q=%0b len=%0d t=%0b clr=%0b -> cnt=%0d head=%0d total=%0d ovf=%0b udf=%0b",
             q, l, t, c, cnt, hlen, total, ovf, udf);
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(2);
    n_tests++; if (cnt !== 0)     begin n_fail++; $display("FAIL rst_cnt got %0d want 0", cnt); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %0b want 1", empty); end
    n_tests++; if (full !== 1'b0 || afull !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0b/%0b want 0/0", full, afull); end
    n_tests++; if (hvld !== 1'b0 || hlen !== 0) begin n_fail++; $display("FAIL rst_head got %0b/%0d want 0/0", hvld, hlen); end
    n_tests++; if (total !== 0)   begin n_fail++; $display("FAIL rst_total got %0d want 0", total); end
    n_tests++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b/%0b want 0/0", ovf, udf); end
  endtask

  task automatic test_push_pop();
    int lens[3] = '{64, 1518, 100};
    for (int i = 0; i < 3; i++) begin
      step(1, lens[i], 0, 0);
      n_tests++; if (cnt !== CW'(i + 1)) begin n_fail++; $display("FAIL push_cnt got %0d want %0d", cnt, i + 1); end
    end
    n_tests++; if (afull !== 1'b1) begin n_fail++; $display("FAIL push_afull got %0b want 1", afull); end
    n_tests++; if (hlen !== 64 || hvld !== 1'b1) begin n_fail++; $display("FAIL push_head got %0d want 64", hlen); end
    n_tests++; if (total !== 1682) begin n_fail++; $display("FAIL push_total got %0d want 1682", total); end
    step(0, 0, 1, 0);
    n_tests++; if (hlen !== 1518) begin n_fail++; $display("FAIL pop_head got %0d want 1518", hlen); end
    n_tests++; if (total !== 1618 || cnt !== 2) begin n_fail++; $display("FAIL pop_total got %0d/%0d want 1618/2", total, cnt); end
    n_tests++; if (afull !== 1'b0) begin n_fail++; $display("FAIL pop_afull got %0b want 0", afull); end
  endtask

  task automatic test_overflow();
    step(1, 500, 0, 0);
    step(1, 700, 0, 0);
    n_tests++; if (full !== 1'b1 || cnt !== 4) begin n_fail++; $display("FAIL ovf_full got %0b/%0d want 1/4", full, cnt); end
    step(1, 200, 0, 0);
    n_tests++; if (cnt !== 4 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0d/%0b want 4/1", cnt, ovf); end
    n_tests++; if (total !== 2818 || total !== BW'(m_sum())) begin n_fail++; $display("FAIL ovf_total got %0d want 2818", total); end
    n_tests++; if (hlen !== 1518) begin n_fail++; $display("FAIL ovf_head got %0d want 1518", hlen); end
    step(0, 0, 0, 1);
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %0b want 0", ovf); end
  endtask

  task automatic test_full_both();
    step(1, 300, 1, 0);
    n_tests++; if (cnt !== 4 || ovf !== 1'b0) begin n_fail++; $display("FAIL fb_cnt got %0d/%0b want 4/0", cnt, ovf); end
    n_tests++; if (hlen !== 100) begin n_fail++; $display("FAIL fb_head got %0d want 100", hlen); end
    n_tests++; if (total !== 1600) begin n_fail++; $display("FAIL fb_total got %0d want 1600", total); end
    repeat (3) step(0, 0, 1, 0);
    n_tests++; if (hlen !== 300 || cnt !== 1) begin n_fail++; $display("FAIL fb_drain got %0d/%0d want 300/1", hlen, cnt); end
    step(0, 0, 1, 0);
    n_tests++; if (empty !== 1'b1 || total !== 0 || udf !== 1'b0) begin n_fail++; $display("FAIL fb_empty got %0b/%0d/%0b want 1/0/0", empty, total, udf); end
  endtask

  task automatic test_underflow();
    step(0, 0, 1, 0);
    n_tests++; if (udf !== 1'b1 || cnt !== 0) begin n_fail++; $display("FAIL udf_set got %0b/%0d want 1/0", udf, cnt); end
    step(1, 60, 1, 0);
    n_tests++; if (cnt !== 1 || hlen !== 60 || udf !== 1'b1) begin n_fail++; $display("FAIL udf_push got %0d/%0d/%0b want 1/60/1", cnt, hlen, udf); end
    n_tests++; if (total !== 60) begin n_fail++; $display("FAIL udf_total got %0d want 60", total); end
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    n_tests++; if (udf !== 1'b1) begin n_fail++; $display("FAIL udf_setwins got %0b want 1", udf); end
    step(0, 0, 0, 1);
    n_tests++; if (udf !== 1'b0) begin n_fail++; $display("FAIL udf_clr got %0b want 0", udf); end
    step(1, 0, 0, 0);
    n_tests++; if (hvld !== 1'b1 || hlen !== 0 || cnt !== 1) begin n_fail++; $display("FAIL zero_len got %0b/%0d/%0d want 1/0/1", hvld, hlen, cnt); end
    step(0, 0, 1, 0);
  endtask

  task automatic test_wrap_reset();
    for (int i = 0; i < 10; i++) begin
      int l = $urandom_range(2047, 1);
      step(1, l, (i % 3) != 0, 0);
      n_tests++; if (hlen !== LW'(m_head())) begin n_fail++; $display("FAIL wrap_head[%0d] got %0d want %0d", i, hlen, m_head()); end
      n_tests++; if (total !== BW'(m_sum()) || cnt !== CW'(exp_q.size())) begin n_fail++; $display("FAIL wrap_total[%0d] got %0d/%0d want %0d/%0d", i, total, cnt, m_sum(), exp_q.size()); end
    end
    while (exp_q.size() > 2) step(0, 0, 1, 0);
    while (exp_q.size() < 2) step(1, 77, 0, 0);
    n_tests++; if (cnt !== 2) begin n_fail++; $display("FAIL wrap_pre got %0d want 2", cnt); end
    apply_reset(1);
    n_tests++; if (cnt !== 0 || empty !== 1'b1 || hvld !== 1'b0 || hlen !== 0) begin n_fail++; $display("FAIL mid_rst got %0d/%0b/%0b/%0d want 0/1/0/0", cnt, empty, hvld, hlen); end
    n_tests++; if (total !== 0 || ovf !== 1'b0 || udf !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL mid_rst_st got %0d/%0b/%0b want 0/0/0", total, ovf, udf); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_push_pop();
    test_overflow();
    test_full_both();
    test_underflow();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
